// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Request / output handshake bundle of instr_encoder.
//                Request side: req_valid, req_ready, req_kind, req_rd,
//                req_rs1, req_rs2, req_funct3, req_funct7b5, req_imm.
//                Output side : out_valid, out_ready, out_instr, out_addr,
//                err (one-cycle pulse when a request is rejected).
//                slave  modport : the encoder.
//                master modport : the request producer / word consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_kind;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport slave (
        input  req_valid, req_kind, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr, err
    );

    modport master (
        output req_valid, req_kind, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Builds RV32I machine words from decoded field requests and
//                streams them out with ascending addresses (BASE_ADDR + 4n).
//                Expands the LI pseudo-instruction into LUI/ADDI.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - instr_encoder_if.slave (request in, word out, err)
//  Parameters  : BASE_ADDR - address of the first emitted word
//                ADDR_W    - width of out_addr (must match the interface)
//  Build macro : INSTR_ENCODER_LI_EN - when defined, LI (kind 10) expansion
//                and the LI2 state are compiled in; otherwise kind 10 is
//                rejected like any other illegal kind.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    instr_encoder_if.slave bus
);

    // Request kinds
    localparam logic [3:0] c_K_LOAD   = 4'd0;
    localparam logic [3:0] c_K_STORE  = 4'd1;
    localparam logic [3:0] c_K_R      = 4'd2;
    localparam logic [3:0] c_K_BRANCH = 4'd3;
    localparam logic [3:0] c_K_IALU   = 4'd4;
    localparam logic [3:0] c_K_JAL    = 4'd5;
    localparam logic [3:0] c_K_JALR   = 4'd6;
    localparam logic [3:0] c_K_AUIPC  = 4'd7;
    localparam logic [3:0] c_K_LUI    = 4'd8;
    localparam logic [3:0] c_K_CSR    = 4'd9;
    localparam logic [3:0] c_K_LI     = 4'd10;
    localparam logic [3:0] c_K_NOP    = 4'd11;

    // Major opcodes
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_CSR    = 7'b1110011;

    localparam logic [31:0]       c_NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(4);

`ifdef INSTR_ENCODER_LI_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LI2  = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0
    } state_t;
`endif

    state_t            r_state;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic        w_free;
    logic        w_xfer;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_word0;
    logic [11:0] w_ialu_imm;

`ifdef INSTR_ENCODER_LI_EN
    logic [31:0] r_pend;   // ADDI half of a two-word LI
    logic        w_two;
    logic [31:0] w_word1;
    logic        w_li_fits;
    logic [19:0] w_li_hi;
`endif

    assign w_free      = !r_out_valid || bus.out_ready;
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_req_ready = (r_state == S_IDLE) && w_free;
    assign w_accept    = bus.req_valid && w_req_ready;

    // Shift-immediate forms carry funct7[5] in bit 30 and a 5-bit shamt.
    assign w_ialu_imm = (bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b101)
                      ? {1'b0, bus.req_funct7b5, 5'b0, bus.req_imm[4:0]}
                      : bus.req_imm[11:0];

`ifdef INSTR_ENCODER_LI_EN
    // Sign-fits-12 means bits [31:11] are all copies of the sign.
    assign w_li_fits = (bus.req_imm[31:11] == {21{bus.req_imm[11]}});
    // (imm + 0x800) >> 12: the low-half add only carries out via imm[11].
    assign w_li_hi   = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};
`endif

    always_comb begin
        w_legal = 1'b1;
        w_word0 = '0;
`ifdef INSTR_ENCODER_LI_EN
        w_two   = 1'b0;
        w_word1 = {bus.req_imm[11:0], bus.req_rd, 3'b000, bus.req_rd, c_OP_IALU};
`endif
        case (bus.req_kind)
            c_K_LOAD: w_word0 = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                                 bus.req_rd, c_OP_LOAD};
            c_K_STORE: w_word0 = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1,
                                  bus.req_funct3, bus.req_imm[4:0], c_OP_STORE};
            c_K_R: w_word0 = {1'b0, bus.req_funct7b5, 5'b0, bus.req_rs2, bus.req_rs1,
                              bus.req_funct3, bus.req_rd, c_OP_R};
            c_K_BRANCH: w_word0 = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2,
                                   bus.req_rs1, bus.req_funct3, bus.req_imm[4:1],
                                   bus.req_imm[11], c_OP_BRANCH};
            c_K_IALU: w_word0 = {w_ialu_imm, bus.req_rs1, bus.req_funct3,
                                 bus.req_rd, c_OP_IALU};
            c_K_JAL: w_word0 = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11],
                                bus.req_imm[19:12], bus.req_rd, c_OP_JAL};
            c_K_JALR: w_word0 = {bus.req_imm[11:0], bus.req_rs1, 3'b000,
                                 bus.req_rd, c_OP_JALR};
            c_K_AUIPC: w_word0 = {bus.req_imm[31:12], bus.req_rd, c_OP_AUIPC};
            c_K_LUI: w_word0 = {bus.req_imm[31:12], bus.req_rd, c_OP_LUI};
            c_K_CSR: w_word0 = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3,
                                bus.req_rd, c_OP_CSR};
            c_K_LI: begin
`ifdef INSTR_ENCODER_LI_EN
                if (w_li_fits) begin
                    w_word0 = {bus.req_imm[11:0], 5'd0, 3'b000, bus.req_rd, c_OP_IALU};
                end else begin
                    w_word0 = {w_li_hi, bus.req_rd, c_OP_LUI};
                    // A zero low half needs no ADDI after the LUI.
                    w_two   = (bus.req_imm[11:0] != 12'd0);
                end
`else
                w_legal = 1'b0;
`endif
            end
            c_K_NOP: w_word0 = c_NOP;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_addr      <= c_BASE;
            r_err       <= 1'b0;
`ifdef INSTR_ENCODER_LI_EN
            r_pend      <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            // r_addr is both the address of the word held and the next free
            // address; it only moves when a word leaves.
            if (w_xfer) begin
                r_addr      <= r_addr + c_STEP;
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_out_valid <= 1'b1;
                            r_out_instr <= w_word0;
`ifdef INSTR_ENCODER_LI_EN
                            if (w_two) begin
                                r_pend  <= w_word1;
                                r_state <= S_LI2;
                            end
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
`ifdef INSTR_ENCODER_LI_EN
                S_LI2: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_instr <= r_pend;
                        r_state     <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
